intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter PHASE_LEN, default 34: cycles per normal go phase (range 2..127).
REQ-002 SHALL have parameter ALLRED_LEN, default 2: cycles per all-red clearance (range 1..127).
REQ-003 SHALL have parameter MIN_GREEN, default 10: minimum go-phase cycles before pedestrian early termination (range 1..PHASE_LEN).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_enable  input  1  level, 1 = run the intersection.
REQ-007 SHALL have port i_ped_req  input  1  pedestrian request pulse, latched internally.
REQ-008 SHALL have port i_emg_req  input  1  emergency preemption level.
REQ-009 SHALL have port i_emg_dir  input  1  emergency direction, 0 = NS, 1 = EW.
REQ-010 SHALL have port o_start  output  1  start enable to both light units.
REQ-011 SHALL have port o_flag_ns  output  1  car-phase flag to NS light unit, 1 = NS cars go.
REQ-012 SHALL have port o_flag_ew  output  1  car-phase flag to EW light unit, 1 = EW cars go.
REQ-013 SHALL have port o_allred  output  1  all-red override, 1 = all car lamps red.
REQ-014 SHALL have port o_ped_ack  output  1  one-cycle pedestrian acknowledge.
REQ-015 SHALL have port o_state  output  3  state code: IDLE=0, NS_GO=1, EW_GO=2, ALLRED=3, EMG=4.
REQ-016 SHALL have port o_phase_cnt  output  7  cycles elapsed in current state, starting at 0.

Function
REQ-017 SHALL implement states IDLE, NS_GO, EW_GO, ALLRED, EMG plus a 2-bit registered next-target (NS_GO, EW_GO, EMG).
REQ-018 SHALL clear o_phase_cnt to 0 on every state transition and increment it by 1 per cycle otherwise, saturating at 127.
REQ-019 SHALL move IDLE -> NS_GO on the edge where i_enable = 1.
REQ-020 SHALL leave NS_GO/EW_GO when o_phase_cnt == PHASE_LEN-1, entering ALLRED with target set to the opposite go state, so each go phase lasts exactly PHASE_LEN cycles.
REQ-021 SHALL leave ALLRED when o_phase_cnt == ALLRED_LEN-1, entering the registered target.
REQ-022 SHALL drive o_start = 1 and o_allred = 0 in NS_GO, EW_GO and EMG; o_start = 0 and o_allred = 1 in ALLRED; all outputs 0 in IDLE.
REQ-023 SHALL drive o_flag_ns = 1, o_flag_ew = 0 in NS_GO; o_flag_ns = 0, o_flag_ew = 1 in EW_GO; in EMG o_flag_ns = ~dir, o_flag_ew = dir, with dir sampled on EMG entry.
REQ-024 SHALL, while i_emg_req = 1 in NS_GO or EW_GO, enter ALLRED next cycle with target EMG; i_emg_req arriving during ALLRED SHALL retarget to EMG.
REQ-025 SHALL leave EMG when i_emg_req = 0, entering ALLRED with target opposite the served emergency direction.
REQ-026 SHALL give emergency priority over pedestrian termination and over normal phase expiry in the same cycle.
REQ-027 SHALL, on i_enable = 0 in any state, enter IDLE next cycle and clear the pedestrian latch.
REQ-028 SHALL keep registered outputs glitch-free; all outputs are decoded from state registers only.

Reset
REQ-029 SHALL, when reset_n = 0 at a clock edge, force state IDLE, o_phase_cnt 0, target NS_GO, pedestrian latch 0, emergency dir 0, all outputs 0, including mid-phase.

Configuration
REQ-030 SHALL compile pedestrian logic only when macro INTERSECTION_PED_REQ_EN is defined.
REQ-031 SHALL with INTERSECTION_PED_REQ_EN: set latch on i_ped_req = 1; in a go state with latch set, exit to ALLRED when o_phase_cnt >= MIN_GREEN-1; pulse o_ped_ack = 1 for the first cycle of the next go state and clear the latch there; a new i_ped_req in that cycle re-sets the latch (set wins).
REQ-032 SHALL without INTERSECTION_PED_REQ_EN: ignore i_ped_req, tie o_ped_ack to 0, go phases always PHASE_LEN cycles.

Verification
REQ-033 SHALL cover: defaults, reset release, i_enable = 1 -> NS_GO 34 cycles, ALLRED 2, EW_GO 34, ALLRED 2, repeating period 72.
REQ-034 SHALL cover: macro defined, i_ped_req pulse at NS_GO cnt 3 -> NS_GO ends after cnt 9 (10 cycles), ALLRED 2, EW_GO first cycle o_ped_ack = 1.
REQ-035 SHALL cover: i_emg_req = 1, i_emg_dir = 1 at NS_GO cnt 5 -> ALLRED 2 cycles, EMG with o_flag_ew = 1; drop request -> ALLRED 2, then NS_GO.
REQ-036 SHALL cover: reset_n = 0 at EW_GO cnt 20 -> next cycle o_state = 0, o_phase_cnt = 0, all outputs 0.
REQ-037 SHALL cover: i_enable = 0 during ALLRED -> IDLE next cycle; re-enable -> NS_GO with o_phase_cnt = 0.
REQ-038 SHALL cover: macro undefined, i_ped_req pulses every 5 cycles -> go phases stay 34 cycles, o_ped_ack never 1.

Source files
------------

// File: rtl/intersection_ctrl.sv
// Two-way intersection phase controller: NS/EW go phases separated by all-red clearance, with emergency preemption.
// Define INTERSECTION_PED_REQ_EN to build the pedestrian early-termination logic.
module intersection_ctrl #(
  parameter int PHASE_LEN  = 34,
  parameter int ALLRED_LEN = 2,
  parameter int MIN_GREEN  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_enable,
  input  logic       i_ped_req,
  input  logic       i_emg_req,
  input  logic       i_emg_dir,
  output logic       o_start,
  output logic       o_flag_ns,
  output logic       o_flag_ew,
  output logic       o_allred,
  output logic       o_ped_ack,
  output logic [2:0] o_state,
  output logic [6:0] o_phase_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NS_GO  = 3'd1,
    S_EW_GO  = 3'd2,
    S_ALLRED = 3'd3,
    S_EMG    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    T_NS  = 2'd0,
    T_EW  = 2'd1,
    T_EMG = 2'd2
  } tgt_e;

  localparam logic [6:0] PHASE_LAST  = 7'(PHASE_LEN - 1);
  localparam logic [6:0] ALLRED_LAST = 7'(ALLRED_LEN - 1);
  localparam logic [6:0] CNT_MAX     = 7'd127;

  state_e     state_q, state_d;
  tgt_e       tgt_q, tgt_d;
  tgt_e       allred_tgt_s;
  logic       dir_q, dir_d;
  logic [6:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic       flag_ns_q, flag_ns_d;
  logic       flag_ew_q, flag_ew_d;
  logic       allred_q, allred_d;
  logic       ped_term_s;

  // An emergency request seen during clearance overrides the pending target immediately.
  assign allred_tgt_s = i_emg_req ? T_EMG : tgt_q;

  // Next-state, clearance target and emergency direction selection.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    if (!i_enable) begin
      state_d = S_IDLE;
      tgt_d   = T_NS;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_NS_GO;
        end
        S_NS_GO, S_EW_GO: begin
          // Emergency outranks both phase expiry and pedestrian termination.
          if (i_emg_req) begin
            state_d = S_ALLRED;
            tgt_d   = T_EMG;
          end else if ((cnt_q == PHASE_LAST) || ped_term_s) begin
            state_d = S_ALLRED;
            tgt_d   = (state_q == S_NS_GO) ? T_EW : T_NS;
          end else begin
            state_d = state_q;
          end
        end
        S_ALLRED: begin
          tgt_d = allred_tgt_s;
          if (cnt_q == ALLRED_LAST) begin
            case (allred_tgt_s)
              T_NS:    state_d = S_NS_GO;
              T_EW:    state_d = S_EW_GO;
              T_EMG: begin
                state_d = S_EMG;
                dir_d   = i_emg_dir;
              end
              default: state_d = S_NS_GO;
            endcase
          end else begin
            state_d = S_ALLRED;
          end
        end
        S_EMG: begin
          if (!i_emg_req) begin
            state_d = S_ALLRED;
            tgt_d   = dir_q ? T_NS : T_EW;
          end else begin
            state_d = S_EMG;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Phase counter restarts on any state change and saturates otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 7'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  // Lamp-unit outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    start_d   = 1'b0;
    flag_ns_d = 1'b0;
    flag_ew_d = 1'b0;
    allred_d  = 1'b0;
    case (state_d)
      S_NS_GO: begin
        start_d   = 1'b1;
        flag_ns_d = 1'b1;
      end
      S_EW_GO: begin
        start_d   = 1'b1;
        flag_ew_d = 1'b1;
      end
      S_EMG: begin
        start_d   = 1'b1;
        flag_ns_d = ~dir_d;
        flag_ew_d = dir_d;
      end
      S_ALLRED: begin
        allred_d = 1'b1;
      end
      default: begin
        start_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tgt_q     <= T_NS;
      dir_q     <= 1'b0;
      cnt_q     <= 7'd0;
      start_q   <= 1'b0;
      flag_ns_q <= 1'b0;
      flag_ew_q <= 1'b0;
      allred_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      flag_ns_q <= flag_ns_d;
      flag_ew_q <= flag_ew_d;
      allred_q  <= allred_d;
    end
  end

`ifdef INTERSECTION_PED_REQ_EN
  localparam logic [6:0] MIN_LAST = 7'(MIN_GREEN - 1);

  logic ped_latch_q, ped_latch_d;
  logic ped_ack_q, ped_ack_d;
  logic enter_go_s;

  // The ack cycle is excluded so a still-set latch cannot cut the new phase short.
  assign ped_term_s = ped_latch_q && !ped_ack_q && (cnt_q >= MIN_LAST);
  assign enter_go_s = ((state_d == S_NS_GO) || (state_d == S_EW_GO)) && (state_d != state_q);

  // Pedestrian latch and acknowledge; a fresh request wins over the clear.
  always_comb begin
    ped_latch_d = ped_latch_q;
    ped_ack_d   = 1'b0;
    if (!i_enable) begin
      ped_latch_d = 1'b0;
      ped_ack_d   = 1'b0;
    end else begin
      ped_ack_d = enter_go_s && ped_latch_q;
      if (i_ped_req) begin
        ped_latch_d = 1'b1;
      end else if (ped_ack_q) begin
        ped_latch_d = 1'b0;
      end else begin
        ped_latch_d = ped_latch_q;
      end
    end
  end

  // Pedestrian registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ped_latch_q <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      ped_latch_q <= ped_latch_d;
      ped_ack_q   <= ped_ack_d;
    end
  end

  assign o_ped_ack = ped_ack_q;
`else
  logic unused_ped_s;

  assign unused_ped_s = i_ped_req;
  assign ped_term_s   = 1'b0;
  assign o_ped_ack    = 1'b0;
`endif

  assign o_start     = start_q;
  assign o_flag_ns   = flag_ns_q;
  assign o_flag_ew   = flag_ew_q;
  assign o_allred    = allred_q;
  assign o_state     = state_q;
  assign o_phase_cnt = cnt_q;

endmodule
